// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver (and the future transmitter).
//   uart_rx_state_t          : receiver FSM state encoding
//   clks_per_bit(clk_hz,baud): clock cycles per bit period
// Configuration macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  // Integer division is the intended rounding; the error is well inside
  // the mid-bit sampling margin for the supported clock/baud pairs.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for asynchronous inputs.
//   clk    in            destination clock
//   rst_n  in            asynchronous active-low reset
//   i_d    in  [WIDTH]   asynchronous input
//   o_q    out [WIDTH]   synchronised output
// Both flops reset to RESET_VAL (all ones by default, matching an idle UART line).
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN), mid-bit sampling,
// start-bit glitch rejection, framing error and overrun detection, and a
// one-byte holding register behind a valid/ready handshake.
//   clk           in        system clock (CLK_HZ)
//   rst_n         in        asynchronous active-low reset
//   uart_rx       in        raw serial line, idle high, asynchronous
//   rx_data       out [8]   received byte, stable while rx_valid
//   rx_valid      out       holding register full
//   rx_ready      in        consumer accepts (transfer on rx_valid && rx_ready)
//   rx_frame_err  out       one-cycle pulse: stop bit sampled low
//   rx_overrun    out       one-cycle pulse: completed byte dropped
//   rx_parity_err out       one-cycle pulse: even parity mismatch (0 if parity disabled)
// Configuration macro: UART_RX_PARITY_EN.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  // CLKS_PER_BIT must be at least 16 for the half-bit start check to be meaningful.
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  logic           w_rx_s;
  uart_rx_state_t r_state;
  uart_rx_state_t w_state_next;
  logic [CW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [7:0]     r_rx_data;
  logic           r_rx_valid;
  logic           r_frame_err;
  logic           r_overrun;

  logic w_half_done;
  logic w_bit_done;
  logic w_cnt_clr;
  logic w_bit_clr;
  logic w_shift_en;
  logic w_load_byte;
  logic w_overrun;
  logic w_frame_err;
  logic w_stop_sample;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (uart_rx),
    .o_q   (w_rx_s)
  );

  assign w_half_done = (r_baud_cnt == HALF_TC);
  assign w_bit_done  = (r_baud_cnt == FULL_TC);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_sample;
  logic r_par_bit;
  logic r_parity_err;
`endif

  // Next-state and datapath control.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_clr     = 1'b0;
    w_bit_clr     = 1'b0;
    w_shift_en    = 1'b0;
    w_load_byte   = 1'b0;
    w_overrun     = 1'b0;
    w_frame_err   = 1'b0;
    w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        w_bit_clr = 1'b1;
        if (!w_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (w_half_done) begin
          w_cnt_clr    = 1'b1;
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_cnt_clr    = 1'b1;
          w_par_sample = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit of margin
        // for a back-to-back start edge.
        if (w_bit_done) begin
          w_cnt_clr     = 1'b1;
          w_stop_sample = 1'b1;
          if (w_rx_s) begin
            if (!r_rx_valid || rx_ready) begin
              w_load_byte = 1'b1;
            end else begin
              w_overrun = 1'b1;
            end
            w_state_next = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_baud_cnt <= '0;
      end else if (!w_bit_done) begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en && (r_bit_idx != 3'd7)) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
    end
  end

  // Holding register; a load in the same cycle as a handshake keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load_byte) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_sample) begin
        r_par_bit <= w_rx_s;
      end
      r_parity_err <= w_stop_sample & (^{r_shift, r_par_bit});
    end
  end

  assign rx_parity_err = r_parity_err;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
// Directed testbench for uart_rx_deser at 12 MHz / 9600 baud (1250 clocks per bit).
// Line stimulus is driven on the falling clock edge; outputs are observed on the
// falling edge by a monitor that counts pulses and records the last delivered byte.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_deser;
  import uart_pkg::*;

  localparam int CPB = 1250;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 13128;
`else
  localparam int LAT = 11878;
`endif

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_parity_err;

  int errors;
  int checks;

  int cyc;
  int fallCyc;
  int nValidRise;
  int nValidHigh;
  int nFrame;
  int nOverrun;
  int nParity;
  int lastRiseCyc;
  logic [7:0] lastData;
  logic prevValid;

  uart_rx_deser #(
    .CLK_HZ (12_000_000),
    .BAUD   (9600)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value equals the number of rising edges seen so far.
  always @(posedge clk) cyc = cyc + 1;

  // Output monitor, sampling half a cycle after each rising edge.
  always @(negedge clk) begin
    if (rx_valid && !prevValid) begin
      nValidRise  = nValidRise + 1;
      lastRiseCyc = cyc;
      lastData    = rx_data;
    end
    if (rx_valid)      nValidHigh = nValidHigh + 1;
    if (rx_frame_err)  nFrame     = nFrame + 1;
    if (rx_overrun)    nOverrun   = nOverrun + 1;
    if (rx_parity_err) nParity    = nParity + 1;
    prevValid = rx_valid;
  end

  // Drive one full frame LSB first; must be called on a falling edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit);
    logic [10:0] bits;
    int nBits;
`ifdef UART_RX_PARITY_EN
    bits  = {1'b0, stopBit, parBit, data, 1'b0};
    nBits = 11;
`else
    bits  = {2'b00, stopBit, data, 1'b0};
    nBits = 10;
    if (parBit) begin end
`endif
    for (int i = 0; i < nBits; i++) begin
      uart_rx = bits[i];
      if (i == 0) fallCyc = cyc;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got=%b exp=0", rx_overrun); end
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_err got=%b exp=0", rx_parity_err); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch;
    int v0, f0, o0;
    v0 = nValidRise; f0 = nFrame; o0 = nOverrun;
    rx_ready = 1'b1;
    uart_rx  = 1'b0;
    repeat (119) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2000) @(negedge clk);
    checks++; if (nValidRise - v0 !== 0) begin errors++; $display("[TB] FAIL glitch_valid got=%0d exp=0", nValidRise - v0); end
    checks++; if (nFrame - f0 !== 0) begin errors++; $display("[TB] FAIL glitch_frame_err got=%0d exp=0", nFrame - f0); end
    checks++; if (nOverrun - o0 !== 0) begin errors++; $display("[TB] FAIL glitch_overrun got=%0d exp=0", nOverrun - o0); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("[TB] FAIL glitch_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
  endtask

  task automatic test_single_byte;
    int v0, h0, f0, o0, lat;
    v0 = nValidRise; h0 = nValidHigh; f0 = nFrame; o0 = nOverrun;
    rx_ready = 1'b1;
    applyStimulus(8'h68, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    lat = lastRiseCyc - fallCyc;
    checks++; if (nValidRise - v0 !== 1) begin errors++; $display("[TB] FAIL byte_valid_count got=%0d exp=1", nValidRise - v0); end
    checks++; if (lastData !== 8'h68) begin errors++; $display("[TB] FAIL byte_data got=%h exp=68", lastData); end
    checks++; if (lat < LAT - 2 || lat > LAT + 2) begin errors++; $display("[TB] FAIL byte_latency got=%0d exp=%0d+-2", lat, LAT); end
    checks++; if (nValidHigh - h0 !== 1) begin errors++; $display("[TB] FAIL byte_valid_width got=%0d exp=1", nValidHigh - h0); end
    checks++; if (nFrame - f0 !== 0) begin errors++; $display("[TB] FAIL byte_frame_err got=%0d exp=0", nFrame - f0); end
    checks++; if (nOverrun - o0 !== 0) begin errors++; $display("[TB] FAIL byte_overrun got=%0d exp=0", nOverrun - o0); end
  endtask

  task automatic test_back_to_back_overrun;
    int v0, o0;
    v0 = nValidRise; o0 = nOverrun;
    rx_ready = 1'b0;
    applyStimulus(8'h01, 1'b1, 1'b1);
    applyStimulus(8'h02, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (nValidRise - v0 !== 1) begin errors++; $display("[TB] FAIL ovr_valid_count got=%0d exp=1", nValidRise - v0); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("[TB] FAIL ovr_held_data got=%h exp=01", rx_data); end
    checks++; if (nOverrun - o0 !== 1) begin errors++; $display("[TB] FAIL ovr_pulse_count got=%0d exp=1", nOverrun - o0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid_held got=%b exp=1", rx_valid); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_valid_cleared got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("[TB] FAIL ovr_data_after got=%h exp=01", rx_data); end
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = nValidRise; f0 = nFrame;
    rx_ready = 1'b1;
    applyStimulus(8'h55, 1'b0, 1'b1);
    // Line held low (break) well beyond a frame time.
    repeat (6000) @(negedge clk);
    checks++; if (nFrame - f0 !== 1) begin errors++; $display("[TB] FAIL ferr_pulse_count got=%0d exp=1", nFrame - f0); end
    checks++; if (nValidRise - v0 !== 0) begin errors++; $display("[TB] FAIL ferr_valid got=%0d exp=0", nValidRise - v0); end
    checks++; if (dut.r_state !== ST_WAIT_HIGH) begin errors++; $display("[TB] FAIL ferr_wait_state got=%0d exp=%0d", dut.r_state, ST_WAIT_HIGH); end
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("[TB] FAIL ferr_idle_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    repeat (2000) @(negedge clk);
    checks++; if (nValidRise - v0 !== 0) begin errors++; $display("[TB] FAIL ferr_no_spurious got=%0d exp=0", nValidRise - v0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, o0;
    rx_ready = 1'b1;
    // Start bit and first three data bits of 0xA5 (LSB first: 1,0,1).
    uart_rx = 1'b0; repeat (CPB) @(negedge clk);
    uart_rx = 1'b1; repeat (CPB) @(negedge clk);
    uart_rx = 1'b0; repeat (CPB) @(negedge clk);
    uart_rx = 1'b1; repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_outputs got=%b/%h exp=0/00", rx_valid, rx_data); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("[TB] FAIL rstmid_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    v0 = nValidRise; f0 = nFrame; o0 = nOverrun;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (nValidRise - v0 !== 1) begin errors++; $display("[TB] FAIL rstmid_valid_count got=%0d exp=1", nValidRise - v0); end
    checks++; if (lastData !== 8'h3C) begin errors++; $display("[TB] FAIL rstmid_data got=%h exp=3c", lastData); end
    checks++; if ((nFrame - f0) + (nOverrun - o0) !== 0) begin errors++; $display("[TB] FAIL rstmid_errors got=%0d exp=0", (nFrame - f0) + (nOverrun - o0)); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    rx_ready = 1'b1;
    v0 = nValidRise; p0 = nParity;
    applyStimulus(8'h07, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (nParity - p0 !== 1) begin errors++; $display("[TB] FAIL par_bad_pulse got=%0d exp=1", nParity - p0); end
    checks++; if (nValidRise - v0 !== 1 || lastData !== 8'h07) begin errors++; $display("[TB] FAIL par_bad_data got=%0d/%h exp=1/07", nValidRise - v0, lastData); end
    v0 = nValidRise; p0 = nParity;
    applyStimulus(8'h07, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (nParity - p0 !== 0) begin errors++; $display("[TB] FAIL par_good_pulse got=%0d exp=0", nParity - p0); end
    checks++; if (nValidRise - v0 !== 1 || lastData !== 8'h07) begin errors++; $display("[TB] FAIL par_good_data got=%0d/%h exp=1/07", nValidRise - v0, lastData); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0; cyc = 0; fallCyc = 0;
    nValidRise = 0; nValidHigh = 0; nFrame = 0; nOverrun = 0; nParity = 0;
    lastRiseCyc = 0; lastData = 8'h00; prevValid = 1'b0;
    rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_glitch;
    test_single_byte;
    test_back_to_back_overrun;
    test_frame_error;
    test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
